armleocpu_div_ctrl: RTL and testbench

//  Sequencer for armleocpu_unsigned_divider implementing RV32M DIV/DIVU/REM/REMU semantics.

---
 rtl/armleocpu_div_ctrl_pkg.sv | 24 ++
 rtl/armleocpu_unsigned_divider.sv | 48 ++++
 rtl/armleocpu_div_ctrl.sv | 130 +++++++++++++
 tb/tb_armleocpu_div_ctrl.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/armleocpu_div_ctrl_pkg.sv
// armleocpu_defines: divide op codes, controller state encoding and sign helpers
// shared by the RV32M division controller.
package armleocpu_defines;

    localparam logic [1:0] DIV_OP_DIV  = 2'b00;
    localparam logic [1:0] DIV_OP_DIVU = 2'b01;
    localparam logic [1:0] DIV_OP_REM  = 2'b10;
    localparam logic [1:0] DIV_OP_REMU = 2'b11;

    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_WAIT, ST_RESP, ST_DRAIN} div_state_t;

    function automatic logic op_signed(input logic [1:0] op);
        return (op == DIV_OP_DIV) || (op == DIV_OP_REM);
    endfunction

    function automatic logic op_rem(input logic [1:0] op);
        return (op == DIV_OP_REM) || (op == DIV_OP_REMU);
    endfunction

    function automatic logic [31:0] neg_if(input logic n, input logic [31:0] v);
        return n ? -v : v;
    endfunction

endpackage

// File: rtl/armleocpu_unsigned_divider.sv
// armleocpu_unsigned_divider: 32-bit restoring divider, one quotient bit per cycle;
// ready pulses for one cycle 34 cycles after the fetch cycle.
module armleocpu_unsigned_divider (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    output logic        ready_o,
    output logic [31:0] quotient_o,
    output logic [31:0] remainder_o
);

    logic        busy_q;
    logic [5:0]  cnt_q;
    logic [31:0] quot_q, rem_q, dvs_q;
    logic [32:0] shifted, diff;
    logic        ge;

    assign shifted     = {rem_q, quot_q[31]};
    assign diff        = shifted - {1'b0, dvs_q};
    assign ge          = shifted >= {1'b0, dvs_q};
    assign ready_o     = busy_q && (cnt_q == 6'd33);
    assign quotient_o  = quot_q;
    assign remainder_o = rem_q;

    // Counts 0..31 iterate, 32 is an idle settle cycle, 33 signals ready.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
        end else if (fetch_i) begin
            busy_q <= 1'b1;
            cnt_q  <= '0;
            quot_q <= dividend_i;
            rem_q  <= '0;
            dvs_q  <= divisor_i;
        end else if (busy_q) begin
            cnt_q  <= cnt_q + 6'd1;
            busy_q <= cnt_q != 6'd33;
            if (cnt_q < 6'd32) begin
                rem_q  <= ge ? diff[31:0] : shifted[31:0];
                quot_q <= {quot_q[30:0], ge};
            end
        end
    end

endmodule

// File: rtl/armleocpu_div_ctrl.sv
// armleocpu_div_ctrl: RV32M DIV/DIVU/REM/REMU sequencer around the unsigned divider.
// Define ARMLEOCPU_DIV_RESULT_CACHE_EN to reuse the last divided result (DIV-then-REM pairs).
module armleocpu_div_ctrl
    import armleocpu_defines::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_op,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    input  logic            kill,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_result,
    output logic            rsp_div_by_zero,
    output logic            busy
);

    div_state_t      state_q;
    logic [1:0]      op_q;
    logic [XLEN-1:0] a_q, b_q, rsp_result_q;
    logic            fetch_q, rsp_valid_q, dbz_q;
    logic            sgn, div_ready, hit;
    logic [XLEN-1:0] div_quot, div_rem, q_fix, r_fix, hit_result;

    assign sgn       = op_signed(op_q);
    assign q_fix     = neg_if(sgn && (a_q[XLEN-1] ^ b_q[XLEN-1]), div_quot);
    assign r_fix     = neg_if(sgn && a_q[XLEN-1], div_rem);

    assign req_ready       = state_q == ST_IDLE;
    assign busy            = state_q != ST_IDLE;
    assign rsp_valid       = rsp_valid_q;
    assign rsp_result      = rsp_result_q;
    assign rsp_div_by_zero = dbz_q;

    armleocpu_unsigned_divider u_div (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_i     (fetch_q),
        .dividend_i  (neg_if(sgn && a_q[XLEN-1], a_q)),
        .divisor_i   (neg_if(sgn && b_q[XLEN-1], b_q)),
        .ready_o     (div_ready),
        .quotient_o  (div_quot),
        .remainder_o (div_rem)
    );

`ifdef ARMLEOCPU_DIV_RESULT_CACHE_EN
    logic            c_valid_q, c_sgn_q;
    logic [XLEN-1:0] c_a_q, c_b_q, c_quot_q, c_rem_q;

    assign hit        = c_valid_q && (c_a_q == req_a) && (c_b_q == req_b) && (c_sgn_q == op_signed(req_op));
    assign hit_result = op_rem(req_op) ? c_rem_q : c_quot_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            c_valid_q <= 1'b0;
        end else if (kill && (state_q == ST_START || state_q == ST_WAIT)) begin
            c_valid_q <= 1'b0;
        end else if (state_q == ST_WAIT && div_ready) begin
            c_valid_q <= 1'b1;
            c_sgn_q   <= sgn;
            c_a_q     <= a_q;
            c_b_q     <= b_q;
            c_quot_q  <= q_fix;
            c_rem_q   <= r_fix;
        end
    end
`else
    assign hit        = 1'b0;
    assign hit_result = '0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            fetch_q      <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            dbz_q        <= 1'b0;
        end else begin
            fetch_q <= 1'b0;
            case (state_q)
                ST_IDLE: if (req_valid && !kill) begin
                    op_q <= req_op;
                    a_q  <= req_a;
                    b_q  <= req_b;
                    if (req_b == '0) begin
                        state_q      <= ST_RESP;
                        rsp_valid_q  <= 1'b1;
                        rsp_result_q <= op_rem(req_op) ? req_a : '1;
                        dbz_q        <= 1'b1;
                    end else if (op_signed(req_op) && req_a == 32'h8000_0000 && req_b == '1) begin
                        state_q      <= ST_RESP;
                        rsp_valid_q  <= 1'b1;
                        rsp_result_q <= op_rem(req_op) ? '0 : 32'h8000_0000;
                        dbz_q        <= 1'b0;
                    end else if (hit) begin
                        state_q      <= ST_RESP;
                        rsp_valid_q  <= 1'b1;
                        rsp_result_q <= hit_result;
                        dbz_q        <= 1'b0;
                    end else begin
                        state_q <= ST_START;
                        fetch_q <= 1'b1;
                    end
                end
                ST_START: state_q <= kill ? ST_DRAIN : ST_WAIT;
                ST_WAIT: if (kill) begin
                    state_q <= div_ready ? ST_IDLE : ST_DRAIN;
                end else if (div_ready) begin
                    state_q      <= ST_RESP;
                    rsp_valid_q  <= 1'b1;
                    rsp_result_q <= op_rem(op_q) ? r_fix : q_fix;
                    dbz_q        <= 1'b0;
                end
                ST_RESP: if (kill || rsp_ready) begin
                    state_q     <= ST_IDLE;
                    rsp_valid_q <= 1'b0;
                end
                ST_DRAIN: if (div_ready) state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_armleocpu_div_ctrl.sv
// tb_armleocpu_div_ctrl: directed vectors for the RV32M division controller,
// covering signed/unsigned results, special cases, kill paths and result hold.
module tb_armleocpu_div_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, req_valid, req_ready, kill, rsp_valid, rsp_ready, rsp_div_by_zero, busy;
    logic [1:0]  req_op;
    logic [31:0] req_a, req_b, rsp_result;
    int          n_vec = 0, n_err = 0, fetch_cnt = 0;

`ifdef ARMLEOCPU_DIV_RESULT_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    logic        m_valid = 1'b0, m_sgn;
    logic [31:0] m_a, m_b;

    armleocpu_div_ctrl dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b), .kill(kill),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_div_by_zero(rsp_div_by_zero), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (dut.fetch_q) fetch_cnt <= fetch_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!req_ready && n < 100) begin tick(); n++; end
        chk({tag, "_idle"}, {31'b0, req_ready}, 32'd1);
    endtask

    task automatic handshake(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int hold);
        int lat;
        logic sgn, special, hitm;
        sgn     = (op == 2'b00) || (op == 2'b10);
        special = (b == 0) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        hitm    = CACHE && m_valid && m_a == a && m_b == b && m_sgn == sgn;
        wait_ready(tag);
        handshake(op, a, b);
        lat = 1;
        while (!rsp_valid && lat < 100) begin tick(); lat++; end
        chk({tag, "_lat"}, lat, (special || hitm) ? 32'd1 : 32'd36);
        chk({tag, "_res"}, rsp_result, exp);
        chk({tag, "_dbz"}, {31'b0, rsp_div_by_zero}, {31'b0, b == 0});
        if (!special && !hitm) begin m_valid = 1'b1; m_a = a; m_b = b; m_sgn = sgn; end
        for (int i = 0; i < hold; i++) begin
            tick();
            chk({tag, "_hold"}, rsp_result, exp);
            chk({tag, "_hold_v"}, {31'b0, rsp_valid}, 32'd1);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk({tag, "_drop"}, {31'b0, rsp_valid}, 32'd0);
        chk({tag, "_back"}, {31'b0, req_ready}, 32'd1);
    endtask

    initial begin
        int f0, n;
        logic seen;
        rst_n = 1'b0; req_valid = 1'b0; kill = 1'b0; rsp_ready = 1'b0;
        req_op = '0; req_a = '0; req_b = '0;
        repeat (3) tick();
        chk("rst_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_result", rsp_result, 32'd0);
        chk("rst_dbz", {31'b0, rsp_div_by_zero}, 32'd0);
        chk("rst_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        rst_n = 1'b1;
        tick();

        do_op("divu", 2'b01, 32'd100, 32'd7, 32'd14, 0);
        do_op("remu", 2'b11, 32'd100, 32'd7, 32'd2, 0);
        do_op("div_neg", 2'b00, -32'sd100, 32'd7, 32'hFFFF_FFF2, 0);
        do_op("rem_neg", 2'b10, -32'sd100, 32'd7, 32'hFFFF_FFFE, 0);
        do_op("div_nb", 2'b00, 32'd7, -32'sd2, 32'hFFFF_FFFD, 0);
        do_op("rem_nb", 2'b10, 32'd7, -32'sd2, 32'd1, 0);
        do_op("divu_max", 2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 0);

        f0 = fetch_cnt;
        do_op("div_z", 2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF, 0);
        do_op("remu_z", 2'b11, 32'd5, 32'd0, 32'd5, 0);
        do_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
        do_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0);
        chk("special_nofetch", fetch_cnt - f0, 32'd0);

        // kill during WAIT: no response, idle only after the divider's ready pulse
        wait_ready("kill");
        handshake(2'b01, 32'd1000, 32'd3);
        repeat (9) tick();
        kill = 1'b1;
        tick();
        kill = 1'b0;
        m_valid = 1'b0;
        chk("kill_busy", {31'b0, req_ready}, 32'd0);
        n = 11; seen = 1'b0;
        while (!req_ready && n < 100) begin seen |= rsp_valid; tick(); n++; end
        chk("kill_idle_cycle", n, 32'd36);
        chk("kill_no_rsp", {31'b0, seen | rsp_valid}, 32'd0);
        do_op("after_kill", 2'b01, 32'd9, 32'd3, 32'd3, 0);

        // kill during RESP wins over rsp_ready
        wait_ready("kresp");
        handshake(2'b00, 32'd5, 32'd0);
        chk("kresp_valid", {31'b0, rsp_valid}, 32'd1);
        kill = 1'b1; rsp_ready = 1'b1;
        tick();
        kill = 1'b0; rsp_ready = 1'b0;
        chk("kresp_drop", {31'b0, rsp_valid}, 32'd0);
        chk("kresp_idle", {31'b0, req_ready}, 32'd1);

        // kill in IDLE blocks acceptance
        kill = 1'b1;
        handshake(2'b01, 32'd8, 32'd2);
        kill = 1'b0;
        chk("kidle_busy", {31'b0, busy}, 32'd0);
        chk("kidle_valid", {31'b0, rsp_valid}, 32'd0);

        do_op("hold", 2'b00, 32'd100, 32'd7, 32'd14, 5);
        do_op("pair_rem", 2'b10, 32'd100, 32'd7, 32'd2, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
